// File: rtl/exe_ctrl.sv
// exe_ctrl: 4-register execution controller sequencing an external ALU,
// a timed input port (IN) and a handshaked output port (OUT).
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   instr, imm           {op,ra,rb} and immediate, taken when
//                        instr_valid && instr_ready
//   instr_valid/ready    instruction handshake (ready only in IDLE)
//   ex_in, ex_in_valid   external input data for IN (op 7)
//   ex_out, ex_out_valid external output data for OUT (op 6)
//   ex_out_ready         consumer accepts ex_out
//   alu_op, alu_s1/s2    operands to the external ALU, live only in EXEC
//   alu_result           combinational ALU result
//   zn                   flags {Z,N}
//   in_timeout           sticky, set when an IN aborted on timeout
module exe_ctrl #(
    parameter int IN_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instr,
    input  logic [7:0] imm,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] ex_in,
    input  logic       ex_in_valid,
    output logic [7:0] ex_out,
    output logic       ex_out_valid,
    input  logic       ex_out_ready,
    output logic [3:0] alu_op,
    output logic [7:0] alu_s1,
    output logic [7:0] alu_s2,
    input  logic [7:0] alu_result,
    output logic [1:0] zn,
    output logic       in_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT_IN,
        WAIT_OUT
    } state_t;

    // last WAIT_IN cycle before the abort
    localparam logic [7:0] TERM = 8'(IN_TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] regs [4];
    logic [3:0] op_q;
    logic [1:0] ra_q;
    logic [1:0] rb_q;
    logic [7:0] imm_q;
    logic [7:0] cnt;

    logic [3:0] op_in;
    logic       accept;
    logic       is_exec;
    logic       is_in;
    logic       is_out;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] exec_res;

    logic       wr_en;
    logic [7:0] wr_data;
    logic [1:0] zn_nx;
    logic       to_set;

    assign op_in       = instr[7:4];
    assign instr_ready = (state == IDLE);
    assign accept      = instr_valid && instr_ready;

    assign is_exec = op_in inside {4'h1, 4'h2, 4'h3, 4'h4,
                                   4'h5, 4'h8, 4'hF};
    assign is_in   = (op_in == 4'h7);
    assign is_out  = (op_in == 4'h6);

    assign s1 = regs[ra_q];
    assign s2 = regs[rb_q];

    // the ALU has no immediate input, so LOADIMM bypasses it
    assign exec_res = (op_q == 4'hF) ? imm_q : alu_result;

    always_comb begin
        alu_op = '0;
        alu_s1 = '0;
        alu_s2 = '0;
        if (state == EXEC) begin
            alu_op = op_q;
            alu_s1 = s1;
            alu_s2 = s2;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_exec: state_nx = EXEC;
                        is_in:   state_nx = WAIT_IN;
                        is_out:  state_nx = WAIT_OUT;
                        default: state_nx = IDLE;
                    endcase
                end
            end
            EXEC: state_nx = IDLE;
            WAIT_IN: begin
                if (ex_in_valid || cnt == TERM)
                    state_nx = IDLE;
            end
            WAIT_OUT: begin
                if (ex_out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        zn_nx   = zn;
        to_set  = 1'b0;
        unique case (state)
            EXEC: begin
                wr_en   = 1'b1;
                wr_data = exec_res;
                unique case (op_q)
                    4'h1, 4'h2, 4'h3:
                        zn_nx = {exec_res == 8'h00, exec_res[7]};
                    4'h4: zn_nx[1] = s1[7];
                    4'h5: zn_nx[1] = s1[0];
                    default: zn_nx = zn;
                endcase
            end
            WAIT_IN: begin
                // data arriving on the terminal cycle beats the timeout
                if (ex_in_valid) begin
                    wr_en   = 1'b1;
                    wr_data = ex_in;
                end else if (cnt == TERM) begin
                    wr_en  = 1'b1;
                    to_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= instr[7:4];
            ra_q  <= instr[3:2];
            rb_q  <= instr[1:0];
            imm_q <= imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[ra_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zn         <= '0;
            in_timeout <= 1'b0;
            cnt        <= '0;
        end else begin
            zn <= zn_nx;
            if (to_set)
                in_timeout <= 1'b1;
            if (state == WAIT_IN && state_nx == WAIT_IN)
                cnt <= cnt + 8'd1;
            else
                cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_out       <= '0;
            ex_out_valid <= 1'b0;
        end else if (accept && is_out) begin
            ex_out       <= regs[instr[3:2]];
            ex_out_valid <= 1'b1;
        end else if (state == WAIT_OUT && ex_out_ready) begin
            ex_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exe_ctrl.sv
// Self-checking bench for exe_ctrl: directed table, random program
// against a register/flag model, reset and timeout corner cases.
module tb_exe_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] instr, imm, ex_in;
    logic       instr_valid, ex_in_valid, ex_out_ready;
    logic       instr_ready, ex_out_valid, in_timeout;
    logic [7:0] ex_out, alu_s1, alu_s2, alu_result;
    logic [3:0] alu_op;
    logic [1:0] zn;

    // second instance with a short timeout
    logic [7:0] instr4, imm4, ex_in4;
    logic       iv4, exiv4, exor4;
    logic       rdy4, eov4, to4;
    logic [7:0] eo4, s14, s24, res4;
    logic [3:0] op4;
    logic [1:0] zn4;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_r [4];
    logic [1:0] m_zn;
    logic [7:0] seen_out;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            4'h1: return a + b;
            4'h2: return a - b;
            4'h3: return ~(a & b);
            4'h4: return {a[6:0], 1'b0};
            4'h5: return {1'b0, a[7:1]};
            4'h8: return b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_s1, alu_s2);
    assign res4       = alu_f(op4, s14, s24);

    exe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .imm(imm),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ex_in(ex_in), .ex_in_valid(ex_in_valid),
        .ex_out(ex_out), .ex_out_valid(ex_out_valid),
        .ex_out_ready(ex_out_ready), .alu_op(alu_op),
        .alu_s1(alu_s1), .alu_s2(alu_s2),
        .alu_result(alu_result), .zn(zn),
        .in_timeout(in_timeout)
    );

    exe_ctrl #(.IN_TIMEOUT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .instr(instr4), .imm(imm4),
        .instr_valid(iv4), .instr_ready(rdy4),
        .ex_in(ex_in4), .ex_in_valid(exiv4),
        .ex_out(eo4), .ex_out_valid(eov4),
        .ex_out_ready(exor4), .alu_op(op4),
        .alu_s1(s14), .alu_s2(s24),
        .alu_result(res4), .zn(zn4),
        .in_timeout(to4)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++)
            m_r[i] = 8'h00;
        m_zn = 2'b00;
    endtask

    // Issue one instruction from IDLE and follow it back to IDLE,
    // checking the DUT against the model along the way.
    task automatic do_instr(input logic [3:0] op, input logic [1:0] ra,
                            input logic [1:0] rb, input logic [7:0] im,
                            input int hold, input int dly,
                            input logic [7:0] din);
        logic [7:0] a, b, r;
        int vcnt;
        @(negedge clk);
        chk("ready_before", instr_ready, 1);
        instr = {op, ra, rb};
        imm = im;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = $urandom();
        imm = $urandom();
        a = m_r[ra];
        b = m_r[rb];
        if (op inside {1, 2, 3, 4, 5, 8, 15}) begin
            chk("alu_op", alu_op, op);
            chk("alu_s1", alu_s1, a);
            chk("alu_s2", alu_s2, b);
            chk("ready_exec", instr_ready, 0);
            case (op)
                1: r = 8'((a + b) % 256);
                2: r = 8'((a + 256 - b) % 256);
                3: r = ~(a & b);
                4: r = 8'((a * 2) % 256);
                5: r = a / 2;
                8: r = b;
                default: r = im;
            endcase
            m_r[ra] = r;
            if (op inside {1, 2, 3})
                m_zn = {r == 0, r >= 8'h80};
            else if (op == 4)
                m_zn[1] = a >= 8'h80;
            else if (op == 5)
                m_zn[1] = a[0];
            @(negedge clk);
            chk("ready_wb", instr_ready, 1);
            chk("zn", zn, m_zn);
        end else if (op == 6) begin
            vcnt = 0;
            seen_out = ex_out;
            chk("out_data", ex_out, a);
            chk("ready_out", instr_ready, 0);
            if (ex_out_valid) vcnt++;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("out_hold", ex_out, a);
                chk("ready_hold", instr_ready, 0);
                if (ex_out_valid) vcnt++;
            end
            chk("out_vcycles", vcnt, hold + 1);
            ex_out_ready = 1'b1;
            @(negedge clk);
            ex_out_ready = 1'b0;
            chk("out_vdrop", ex_out_valid, 0);
            chk("out_keep", ex_out, a);
            chk("ready_after_out", instr_ready, 1);
        end else if (op == 7) begin
            chk("ready_in", instr_ready, 0);
            for (int k = 0; k < dly; k++)
                @(negedge clk);
            ex_in = din;
            ex_in_valid = 1'b1;
            @(negedge clk);
            ex_in_valid = 1'b0;
            ex_in = $urandom();
            m_r[ra] = din;
            chk("ready_after_in", instr_ready, 1);
            chk("zn_in", zn, m_zn);
        end else begin
            chk("nop_ready", instr_ready, 1);
            chk("nop_aluop", alu_op, 0);
            chk("nop_zn", zn, m_zn);
        end
    endtask

    task automatic read_reg(input logic [1:0] ra);
        do_instr(4'h6, ra, 2'd0, 8'h00, 0, 0, 8'h00);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] im;
        logic [7:0] val;
        logic [1:0] zn;
    } vec_t;

    vec_t tbl [12];
    int   cyc;

    initial begin
        tbl = '{
            '{4'hF, 2'd1, 2'd0, 8'h05, 8'h05, 2'b00},
            '{4'hF, 2'd2, 2'd0, 8'hFB, 8'hFB, 2'b00},
            '{4'h1, 2'd1, 2'd2, 8'h00, 8'h00, 2'b10},
            '{4'hF, 2'd0, 2'd0, 8'h81, 8'h81, 2'b10},
            '{4'h4, 2'd0, 2'd0, 8'h00, 8'h02, 2'b10},
            '{4'h5, 2'd0, 2'd0, 8'h00, 8'h01, 2'b00},
            '{4'hF, 2'd3, 2'd0, 8'h5A, 8'h5A, 2'b00},
            '{4'h2, 2'd3, 2'd1, 8'h00, 8'h5A, 2'b00},
            '{4'h3, 2'd2, 2'd3, 8'h00, 8'hA5, 2'b01},
            '{4'h8, 2'd1, 2'd2, 8'h00, 8'hA5, 2'b01},
            '{4'h1, 2'd2, 2'd1, 8'h00, 8'h4A, 2'b00},
            '{4'hA, 2'd0, 2'd0, 8'h77, 8'h01, 2'b00}
        };
        rst_n = 1'b0;
        instr = '0; imm = '0; instr_valid = 1'b0;
        ex_in = '0; ex_in_valid = 1'b0; ex_out_ready = 1'b0;
        instr4 = '0; imm4 = '0; iv4 = 1'b0;
        ex_in4 = '0; exiv4 = 1'b0; exor4 = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_valid", ex_out_valid, 0);
        chk("rst_out", ex_out, 0);
        chk("rst_zn", zn, 0);
        chk("rst_to", in_timeout, 0);
        chk("rst_aluop", alu_op, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            do_instr(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].im,
                     0, 0, 8'h00);
            chk("tbl_zn", zn, tbl[i].zn);
            read_reg(tbl[i].ra);
            chk("tbl_val", seen_out, tbl[i].val);
        end

        // OUT with the consumer stalling three cycles
        do_instr(4'h6, 2'd3, 2'd0, 8'h00, 3, 0, 8'h00);
        chk("out_r3", seen_out, 8'h5A);

        // IN with data arriving after ten cycles
        do_instr(4'h7, 2'd2, 2'd0, 8'h00, 0, 10, 8'h3C);
        read_reg(2'd2);
        chk("in_r2", seen_out, 8'h3C);

        for (int n = 0; n < 60; n++) begin
            do_instr(4'($urandom_range(0, 15)),
                     2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)),
                     8'($urandom()),
                     $urandom_range(0, 3),
                     $urandom_range(0, 6),
                     8'($urandom()));
        end
        for (int i = 0; i < 4; i++)
            read_reg(2'(i));
        chk("no_timeout", in_timeout, 0);

        // instr_valid held across a busy OUT; only the final
        // instruction word is taken, and only once
        do_instr(4'hF, 2'd0, 2'd0, 8'h10, 0, 0, 8'h00);
        do_instr(4'hF, 2'd1, 2'd0, 8'h11, 0, 0, 8'h00);
        @(negedge clk);
        instr = {4'h6, 2'd1, 2'd0};
        instr_valid = 1'b1;
        @(negedge clk);
        instr = {4'h2, 2'd2, 2'd3};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("busy_ready", instr_ready, 0);
        end
        instr = {4'h1, 2'd0, 2'd1};
        ex_out_ready = 1'b1;
        @(negedge clk);
        ex_out_ready = 1'b0;
        chk("busy_release", instr_ready, 1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("held_op", alu_op, 4'h1);
        chk("held_s1", alu_s1, 8'h10);
        chk("held_s2", alu_s2, 8'h11);
        m_r[0] = 8'h21;
        m_zn = 2'b00;
        @(negedge clk);
        chk("held_zn", zn, m_zn);
        read_reg(2'd0);
        chk("once_r0", seen_out, 8'h21);

        // reset during WAIT_OUT
        do_instr(4'hF, 2'd3, 2'd0, 8'h5A, 0, 0, 8'h00);
        @(negedge clk);
        instr = {4'h6, 2'd3, 2'd0};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("pre_rst_valid", ex_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", ex_out_valid, 0);
        chk("arst_out", ex_out, 0);
        chk("arst_ready", instr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1 chk("first_ready", instr_ready, 1);

        // reset during EXEC of ADD
        do_instr(4'hF, 2'd1, 2'd0, 8'h07, 0, 0, 8'h00);
        do_instr(4'hF, 2'd2, 2'd0, 8'h09, 0, 0, 8'h00);
        do_instr(4'h1, 2'd3, 2'd3, 8'h00, 0, 0, 8'h00);
        @(negedge clk);
        instr = {4'h1, 2'd1, 2'd2};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("pre_rst_op", alu_op, 4'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_aluop", alu_op, 0);
        chk("arst_s1", alu_s1, 0);
        chk("arst_s2", alu_s2, 0);
        chk("arst_zn", zn, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1 chk("first_ready2", instr_ready, 1);
        read_reg(2'd1);
        chk("no_wb_r1", seen_out, 8'h00);

        // short-timeout instance: abort after four cycles
        chk("t4_rst", to4, 0);
        @(negedge clk);
        instr4 = {4'hF, 2'd2, 2'd0};
        imm4 = 8'h77;
        iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        instr4 = {4'h7, 2'd2, 2'd0};
        iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (rdy4) break;
        end
        chk("t4_cycles", cyc, 4);
        chk("t4_flag", to4, 1);
        instr4 = {4'h6, 2'd2, 2'd0};
        iv4 = 1'b1;
        exor4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        chk("t4_r2", eo4, 8'h00);
        chk("t4_ov", eov4, 1);
        @(negedge clk);
        exor4 = 1'b0;

        // data on the terminal cycle wins over the timeout
        instr4 = {4'h7, 2'd2, 2'd0};
        iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        for (int k = 0; k < 3; k++)
            @(negedge clk);
        chk("t4_wait", rdy4, 0);
        ex_in4 = 8'hC3;
        exiv4 = 1'b1;
        @(negedge clk);
        exiv4 = 1'b0;
        chk("t4_term_ready", rdy4, 1);
        instr4 = {4'h6, 2'd2, 2'd0};
        iv4 = 1'b1;
        exor4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        chk("t4_term_data", eo4, 8'hC3);
        chk("t4_sticky", to4, 1);
        @(negedge clk);
        exor4 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
